// File: rtl/laser_feeder_pkg.sv
// Shared definitions for the laser feeder: state encoding, sizes and payload types.
package laser_feeder_pkg;

  localparam int unsigned NPTS_DEFAULT = 40;  // points per image
  localparam int unsigned COORD_W      = 4;   // coordinate width
  localparam int unsigned ADDR_W       = 6;   // point index width
  localparam int unsigned CNT_W        = 12;  // align/wait counter width

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_STREAM,
    S_WAIT,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pt_t;

  typedef struct packed {
    logic [COORD_W-1:0] c1x;
    logic [COORD_W-1:0] c1y;
    logic [COORD_W-1:0] c2x;
    logic [COORD_W-1:0] c2y;
  } res_t;

endpackage

// File: rtl/laser_pt_mem.sv
// Point memory: one synchronous write port, one asynchronous read port, (x,y) per entry.
// Ports: clk; wr_en/wr_addr/wr_pt write side; rd_addr/rd_pt_c read side.
// Contents are intentionally not reset.
module laser_pt_mem
  import laser_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = NPTS_DEFAULT
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pt_t               wr_pt,
  input  logic [ADDR_W-1:0] rd_addr,
  output pt_t               rd_pt_c
);

  pt_t mem_q [DEPTH];

  // Out-of-range writes are dropped here as a second line of defence.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_pt;
    end
  end

  assign rd_pt_c = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/laser_feeder.sv
// Laser feeder: streams a stored point image to the LASER peer and captures its result.
// Ports: CLK/RST (sync, active-high); LD_* point loading; START run request;
//        PEER_RST, X, Y to the peer; C1X..C2Y, DONE from the peer;
//        R_* captured result, RES_VALID / TIMEOUT pulses, BUSY status.
module laser_feeder
  import laser_feeder_pkg::*;
#(
  parameter int unsigned NPTS    = NPTS_DEFAULT,
  parameter int unsigned LEAD    = 1,
  parameter int unsigned TMO_MAX = 4095
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LD_EN,
  input  logic [ADDR_W-1:0]  LD_ADDR,
  input  logic [COORD_W-1:0] LD_X,
  input  logic [COORD_W-1:0] LD_Y,
  input  logic               START,
  output logic               PEER_RST,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE,
  output logic [COORD_W-1:0] R_C1X,
  output logic [COORD_W-1:0] R_C1Y,
  output logic [COORD_W-1:0] R_C2X,
  output logic [COORD_W-1:0] R_C2Y,
  output logic               RES_VALID,
  output logic               BUSY,
  output logic               TIMEOUT
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  res_t              res_q, res_d;
  pt_t               xy_q, xy_d;
  logic              peer_rst_q, peer_rst_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic              timeout_q, timeout_d;
  logic              wr_en_c;
  pt_t               rd_pt_c;

  // Loads only land while idle; a write in the START cycle completes before streaming.
  assign wr_en_c = LD_EN && (state_q == S_IDLE) && (32'(LD_ADDR) < NPTS);

  laser_pt_mem #(.DEPTH(NPTS)) u_mem (
    .clk     (CLK),
    .wr_en   (wr_en_c),
    .wr_addr (LD_ADDR),
    .wr_pt   ('{x: LD_X, y: LD_Y}),
    .rd_addr (idx_d),
    .rd_pt_c (rd_pt_c)
  );

  // Next-state, index/counter and result capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ALIGN;
          cnt_d   = '0;
        end
      end
      S_ALIGN: begin
        // LEAD of 0 behaves as 1: ALIGN always lasts at least one cycle.
        if (32'(cnt_q) + 32'd1 >= LEAD) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (32'(idx_q) + 32'd1 >= NPTS) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // DONE takes priority over a coincident timeout.
        if (DONE) begin
          state_d = S_REPORT;
          res_d   = '{c1x: C1X, c1y: C1Y, c2x: C2X, c2y: C2Y};
        end else if (32'(cnt_q) >= TMO_MAX) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    xy_d        = '0;
    peer_rst_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_REPORT);
    if (state_d == S_STREAM) begin
      xy_d = rd_pt_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      xy_q        <= '0;
      peer_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      xy_q        <= xy_d;
      peer_rst_q  <= peer_rst_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign PEER_RST  = peer_rst_q;
  assign X         = xy_q.x;
  assign Y         = xy_q.y;
  assign R_C1X     = res_q.c1x;
  assign R_C1Y     = res_q.c1y;
  assign R_C2X     = res_q.c2x;
  assign R_C2Y     = res_q.c2y;
  assign RES_VALID = res_valid_q;
  assign BUSY      = busy_q;
  assign TIMEOUT   = timeout_q;

endmodule
